// File: rtl/srrc_matched_receiver_if.sv
// Sample-stream and decision bus of the SRRC matched receiver.
// The master drives samples in; the slave returns filtered samples and symbol decisions.
interface srrc_matched_receiver_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) ();
  logic signed [IN_W-1:0]  rx_sample;
  logic                    rx_valid;
  logic                    rx_ready;
  logic signed [OUT_W-1:0] filt_out;
  logic                    filt_valid;
  logic                    sym_valid;
  logic                    sym_bit;

  modport master (
    output rx_sample, rx_valid,
    input  rx_ready, filt_out, filt_valid, sym_valid, sym_bit
  );

  modport slave (
    input  rx_sample, rx_valid,
    output rx_ready, filt_out, filt_valid, sym_valid, sym_bit
  );
endinterface

// File: rtl/srrc_matched_receiver.sv
// 33-tap SRRC matched filter built around a single time-shared multiplier,
// followed by symbol decimation and a hard-decision slicer.
module srrc_matched_receiver #(
  parameter int TAPS         = 33,
  parameter int IN_W         = 16,
  parameter int OUT_W        = 16,
  parameter int ACC_W        = 40,
  parameter int SHIFT        = 15,
  parameter int SPS          = 4,
  parameter int SAMPLE_PHASE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  srrc_matched_receiver_if.slave bus
);
  localparam int PTR_W = $clog2(TAPS);
  localparam int PH_W  = $clog2(SPS + 1);
  localparam int PR_W  = 2 * IN_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Half of the symmetric response; taps above the centre mirror onto it.
  function automatic logic signed [15:0] coef_fn(input logic [PTR_W-1:0] k);
    logic [PTR_W-1:0] m;
    m = (k > PTR_W'(16)) ? (PTR_W'(32) - k) : k;
    case (m)
      PTR_W'(0):  coef_fn = -16'sd165;
      PTR_W'(1):  coef_fn = -16'sd63;
      PTR_W'(2):  coef_fn = 16'sd176;
      PTR_W'(3):  coef_fn = 16'sd269;
      PTR_W'(4):  coef_fn = 16'sd50;
      PTR_W'(5):  coef_fn = -16'sd269;
      PTR_W'(6):  coef_fn = -16'sd246;
      PTR_W'(7):  coef_fn = 16'sd253;
      PTR_W'(8):  coef_fn = 16'sd694;
      PTR_W'(9):  coef_fn = 16'sd253;
      PTR_W'(10): coef_fn = -16'sd1230;
      PTR_W'(11): coef_fn = -16'sd2566;
      PTR_W'(12): coef_fn = -16'sd1736;
      PTR_W'(13): coef_fn = 16'sd2566;
      PTR_W'(14): coef_fn = 16'sd9473;
      PTR_W'(15): coef_fn = 16'sd15988;
      PTR_W'(16): coef_fn = 16'sd18622;
      default:    coef_fn = 16'sd0;
    endcase
  endfunction

  logic [1:0]              state_r;
  logic                    rdy_r;
  logic signed [IN_W-1:0]  buf_r [TAPS];
  logic [PTR_W-1:0]        wr_r;
  logic [PTR_W-1:0]        rd_r;
  logic [PTR_W-1:0]        k_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [PH_W-1:0]         phase_r;
  logic signed [OUT_W-1:0] filt_r;
  logic                    fv_r;
  logic                    sv_r;
  logic                    sb_r;

  logic signed [PR_W-1:0]  product_s;
  logic signed [ACC_W-1:0] y_s;
  logic signed [OUT_W-1:0] y_sat_s;

  // Current tap product and the scaled, saturated accumulator result.
  always_comb begin
    product_s = buf_r[rd_r] * coef_fn(k_r);
    y_s       = acc_r >>> SHIFT;
    y_sat_s   = '0;
    if (y_s > SAT_HI) begin
      y_sat_s = SAT_HI[OUT_W-1:0];
    end else if (y_s < SAT_LO) begin
      y_sat_s = SAT_LO[OUT_W-1:0];
    end else begin
      y_sat_s = y_s[OUT_W-1:0];
    end
  end

  // Accept / MAC / output sequencer with sample history and decimation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      rdy_r   <= 1'b1;
      wr_r    <= '0;
      rd_r    <= '0;
      k_r     <= '0;
      acc_r   <= '0;
      phase_r <= '0;
      filt_r  <= '0;
      fv_r    <= 1'b0;
      sv_r    <= 1'b0;
      sb_r    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        buf_r[i] <= '0;
      end
    end else begin
      fv_r <= 1'b0;
      sv_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.rx_valid && rdy_r) begin
            buf_r[wr_r] <= bus.rx_sample;
            rd_r        <= wr_r;
            wr_r        <= (wr_r == PTR_W'(TAPS - 1)) ? '0 : wr_r + PTR_W'(1);
            acc_r       <= '0;
            k_r         <= '0;
            rdy_r       <= 1'b0;
            state_r     <= ST_MAC;
          end
        end
        ST_MAC: begin
          // Walk backwards through history: newest sample meets h[0].
          acc_r <= acc_r + {{(ACC_W-PR_W){product_s[PR_W-1]}}, product_s};
          rd_r  <= (rd_r == '0) ? PTR_W'(TAPS - 1) : rd_r - PTR_W'(1);
          if (k_r == PTR_W'(TAPS - 1)) begin
            state_r <= ST_DONE;
          end else begin
            k_r <= k_r + PTR_W'(1);
          end
        end
        ST_DONE: begin
          filt_r <= y_sat_s;
          fv_r   <= 1'b1;
          if (phase_r == PH_W'(SAMPLE_PHASE)) begin
            sv_r <= 1'b1;
            sb_r <= ~y_sat_s[OUT_W-1];
          end
          phase_r <= (phase_r == PH_W'(SPS - 1)) ? '0 : phase_r + PH_W'(1);
          rdy_r   <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          rdy_r   <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_ready   = rdy_r;
  assign bus.filt_out   = filt_r;
  assign bus.filt_valid = fv_r;
  assign bus.sym_valid  = sv_r;
  assign bus.sym_bit    = sb_r;
endmodule

// File: tb/tb_srrc_matched_receiver.sv
// Randomized self-checking bench for srrc_matched_receiver against a
// direct-convolution reference model.
module tb_srrc_matched_receiver;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  srrc_matched_receiver_if #(.IN_W(16), .OUT_W(16)) rx_if ();

  srrc_matched_receiver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: every sample accepted since reset, outputs produced.
  int   hist[$];
  int   nfilt;
  logic held_bit;

  function automatic longint coef(input int k);
    int h17[17] = '{-165, -63, 176, 269, 50, -269, -246, 253, 694, 253,
                    -1230, -2566, -1736, 2566, 9473, 15988, 18622};
    return longint'(h17[(k > 16) ? 32 - k : k]);
  endfunction

  // Adds one sample and returns the filter output and decision it must produce.
  task automatic model_push(input int v, output int y, output logic sv, output logic sb);
    longint acc;
    longint q;
    hist.push_back(v);
    acc = 0;
    for (int k = 0; k < 33; k++) begin
      int idx;
      idx = hist.size() - 1 - k;
      if (idx >= 0) acc += longint'(hist[idx]) * coef(k);
    end
    q = acc >>> 15;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    y  = int'(q);
    sv = (nfilt % 4 == 0);
    if (sv) held_bit = (y >= 0);
    sb = held_bit;
    nfilt++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_if.rx_valid  = 1'b0;
    rx_if.rx_sample = 16'sd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    hist.delete();
    nfilt    = 0;
    held_bit = 1'b0;
  endtask

  // Feeds one sample and waits (bounded) for its filter output.
  task automatic push(input int v, output int y, output logic sv, output logic sb,
                      output int lat, output logic rdy_low);
    int w;
    w = 0;
    while (rx_if.rx_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    rx_if.rx_sample = 16'(v);
    rx_if.rx_valid  = 1'b1;
    @(posedge clk); #1;
    rx_if.rx_valid = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (rx_if.filt_valid === 1'b1) break;
      if (rx_if.rx_ready !== 1'b0) rdy_low = 1'b0;
    end
    y  = int'(rx_if.filt_out);
    sv = rx_if.sym_valid;
    sb = rx_if.sym_bit;
  endtask

  // Pushes one sample and compares everything the DUT reports with the model.
  task automatic push_check(input int v, input string tag, output int y);
    int ey, lat;
    logic esv, esb, sv, sb, rl;
    model_push(v, ey, esv, esb);
    push(v, y, sv, sb, lat, rl);
    total++;
    if (lat !== 34) begin
      bad++; $display("FAIL %s latency got=%0d exp=34", tag, lat);
    end
    total++;
    if (y !== ey) begin
      bad++; $display("FAIL %s filt_out got=%0d exp=%0d", tag, y, ey);
    end
    total++;
    if (sv !== esv || sb !== esb) begin
      bad++; $display("FAIL %s sym got=%b/%b exp=%b/%b", tag, sv, sb, esv, esb);
    end
    total++;
    if (rl !== 1'b1) begin
      bad++; $display("FAIL %s rx_ready_busy got=high exp=low", tag);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({rx_if.rx_ready, rx_if.filt_valid, rx_if.sym_valid, rx_if.sym_bit} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b exp=1000",
        {rx_if.rx_ready, rx_if.filt_valid, rx_if.sym_valid, rx_if.sym_bit});
    end
    total++;
    if (rx_if.filt_out !== 16'sd0) begin
      bad++; $display("FAIL reset_filt_out got=%0d exp=0", rx_if.filt_out);
    end
  endtask

  task automatic test_impulse(input bit with_reset);
    int y;
    int first, centre, third;
    if (with_reset) do_reset();
    for (int n = 0; n < 33; n++) begin
      push_check((n == 0) ? 32767 : 0, "impulse", y);
      if (n == 0)  first  = y;
      if (n == 2)  third  = y;
      if (n == 16) centre = y;
    end
    total++;
    if (first !== -165 || third !== 175 || centre !== 18621) begin
      bad++; $display("FAIL impulse_taps got=%0d,%0d,%0d exp=-165,175,18621", first, third, centre);
    end
  endtask

  task automatic test_random();
    int y;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      push_check(int'($signed(16'($urandom))), "random", y);
    end
  endtask

  task automatic test_saturation();
    int y;
    do_reset();
    for (int n = 0; n < 33; n++) push_check(32767, "sat_pos", y);
    total++;
    if (y !== 32767) begin
      bad++; $display("FAIL sat_pos_final got=%0d exp=32767", y);
    end
    for (int n = 0; n < 33; n++) push_check(-32768, "sat_neg", y);
    total++;
    if (y !== -32768) begin
      bad++; $display("FAIL sat_neg_final got=%0d exp=-32768", y);
    end
  endtask

  task automatic test_back_to_back();
    int   acc_cyc[$];
    int   exp_q[$];
    int   ey, v, gap_bad, fv_bad;
    logic esv, esb, rdy_before;
    do_reset();
    v = int'($signed(16'($urandom)));
    rx_if.rx_sample = 16'(v);
    rx_if.rx_valid  = 1'b1;
    gap_bad = 0;
    fv_bad  = 0;
    for (int c = 1; c <= 200; c++) begin
      rdy_before = rx_if.rx_ready;
      @(posedge clk); #1;
      if (rdy_before === 1'b1) begin
        acc_cyc.push_back(c);
        model_push(v, ey, esv, esb);
        exp_q.push_back(ey);
      end
      if (rx_if.filt_valid === 1'b1) begin
        if (acc_cyc.size() == 0 || exp_q.size() == 0) begin
          fv_bad++;
        end else begin
          if (c - acc_cyc[acc_cyc.size() - 1] != 34) fv_bad++;
          total++;
          if (rx_if.filt_out !== 16'(exp_q[0])) begin
            bad++; $display("FAIL b2b_filt_out got=%0d exp=%0d", rx_if.filt_out, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
    rx_if.rx_valid = 1'b0;
    for (int i = 1; i < acc_cyc.size(); i++) begin
      if (acc_cyc[i] - acc_cyc[i-1] != 35) gap_bad++;
    end
    total++;
    if (acc_cyc.size() !== 6) begin
      bad++; $display("FAIL b2b_accepts got=%0d exp=6", acc_cyc.size());
    end
    total++;
    if (gap_bad !== 0) begin
      bad++; $display("FAIL b2b_spacing got=%0d bad_gaps exp=0", gap_bad);
    end
    total++;
    if (fv_bad !== 0) begin
      bad++; $display("FAIL b2b_filt_latency got=%0d bad exp=0", fv_bad);
    end
  endtask

  task automatic test_reset_mid_mac();
    int y, seen;
    do_reset();
    for (int n = 0; n < 5; n++) push_check(int'($signed(16'($urandom))), "pre_abort", y);
    rx_if.rx_sample = 16'sd30000;
    rx_if.rx_valid  = 1'b1;
    @(posedge clk); #1;
    rx_if.rx_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rx_if.rx_ready !== 1'b1 || rx_if.filt_valid !== 1'b0 || rx_if.sym_valid !== 1'b0) begin
      bad++; $display("FAIL abort_state got=%b%b%b exp=100",
        rx_if.rx_ready, rx_if.filt_valid, rx_if.sym_valid);
    end
    reset = 1'b0;
    hist.delete();
    nfilt    = 0;
    held_bit = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rx_if.filt_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL abort_no_output got=%0d exp=0", seen);
    end
    test_impulse(1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nfilt = 0;
    held_bit = 1'b0;
    reset = 1'b1;
    rx_if.rx_valid  = 1'b0;
    rx_if.rx_sample = 16'sd0;
    test_reset();
    test_impulse(1'b1);
    test_random();
    test_saturation();
    test_back_to_back();
    test_reset_mid_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
